// File: rtl/ecc_pkg.sv
// Shared ECC definitions: the controller state encoding and the named reduction polynomials.
package ecc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Low-order terms of f(x); the leading x^M term is implicit.
    localparam logic [7:0]   POLY_GF2_8   = 8'h1B;
    localparam logic [63:0]  POLY_GF2_64  = 64'h1B;
    localparam logic [162:0] POLY_GF2_163 = 163'hC9;

endpackage

// File: rtl/ecc_gf2m_step.sv
// One MSB-first interleaved multiply/reduce iteration: shift, fold x^M back through POLY, then add A when the B bit is set.
module ecc_gf2m_step
    import ecc_pkg::*;
#(
    parameter int unsigned    M    = 64,
    parameter logic [M-1:0]   POLY = POLY_GF2_64[M-1:0]
) (
    input  logic [M-1:0] acc_i,
    input  logic [M-1:0] ra_i,
    input  logic         bit_i,
    output logic [M-1:0] acc_o
);

    logic [M-1:0] shifted;

    always_comb begin
        shifted = {acc_i[M-2:0], 1'b0} ^ (acc_i[M-1] ? POLY : '0);
        acc_o   = bit_i ? (shifted ^ ra_i) : shifted;
    end

endmodule

// File: rtl/ecc_gf2m_mul_serial.sv
// Bit-serial GF(2^M) multiplier/squarer, one bit of B per cycle, with valid/ready on both sides.
module ecc_gf2m_mul_serial
    import ecc_pkg::*;
#(
    parameter int unsigned  M     = 64,
    parameter logic [M-1:0] POLY  = POLY_GF2_64[M-1:0],
    parameter int unsigned  CNT_W = $clog2(M)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sq_mode,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] p,
    output logic         busy
);

    state_e           state_q, state_d;
    logic [M-1:0]     acc_q, acc_d;
    logic [M-1:0]     ra_q, ra_d;
    logic [M-1:0]     rb_q, rb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [M-1:0]     step_acc;

    ecc_gf2m_step #(.M(M), .POLY(POLY)) u_step (
        .acc_i (acc_q),
        .ra_i  (ra_q),
        .bit_i (rb_q[cnt_q]),
        .acc_o (step_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            cnt_q   <= cnt_d;
        end
    end

    // The accumulator doubles as the result register, so p holds through DONE and the following IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = sq_mode ? a : b;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(M - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign p         = acc_q;

endmodule

// File: tb/tb_ecc_gf2m_mul_serial.sv
// Self-checking bench: GF(2^M) products from a polynomial multiply-then-reduce model, scoreboarded on every DONE cycle.
module tb_ecc_gf2m_mul_serial;

    localparam int M64 = 64;
    localparam int M8  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        inValid = 1'b0, inReady, sqMode = 1'b0, outValid, outReady = 1'b0, busy;
    logic [63:0] a = '0, b = '0, p;

    logic        inValid8 = 1'b0, inReady8, sqMode8 = 1'b0, outValid8, outReady8 = 1'b0, busy8;
    logic [7:0]  a8 = '0, b8 = '0, p8;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] q64[$];
    logic [63:0] q8[$];

    always #5 clk = ~clk;

    ecc_gf2m_mul_serial #(.M(64), .POLY(64'h1B)) dut64 (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .sq_mode(sqMode),
        .a(a), .b(b), .out_valid(outValid), .out_ready(outReady), .p(p), .busy(busy)
    );

    ecc_gf2m_mul_serial #(.M(8), .POLY(8'h1B)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8), .sq_mode(sqMode8),
        .a(a8), .b(b8), .out_valid(outValid8), .out_ready(outReady8), .p(p8), .busy(busy8)
    );

    // Schoolbook carry-less product, then cancel each term of degree >= m using x^m = poly.
    function automatic logic [63:0] gfMul(input logic [63:0] x, input logic [63:0] y,
                                          input int m, input logic [63:0] poly);
        logic [127:0] prod;
        prod = '0;
        for (int i = 0; i < m; i++)
            if (y[i]) prod ^= (128'(x) << i);
        for (int d = 2 * m - 2; d >= m; d--)
            if (prod[d]) begin
                prod[d] = 1'b0;
                prod ^= (128'(poly) << (d - m));
            end
        return prod[63:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected results enter the queues at the input handshake and leave at the output handshake.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q64.delete();
            q8.delete();
        end else begin
            if (outValid && outReady && q64.size() > 0) void'(q64.pop_front());
            if (inValid && inReady) q64.push_back(gfMul(a, sqMode ? a : b, M64, 64'h1B));
            if (outValid8 && outReady8 && q8.size() > 0) void'(q8.pop_front());
            if (inValid8 && inReady8) q8.push_back(gfMul(64'(a8), 64'(sqMode8 ? a8 : b8), M8, 64'h1B));
        end
    end

    always @(negedge clk) begin
        if (rst && outValid) begin
            if (q64.size() == 0) checkOutput("model64_empty", 64'(outValid), 64'h0);
            else checkOutput("model64", p, q64[0]);
            checkOutput("inReady_in_done", 64'(inReady), 64'h0);
        end
        if (rst && outValid8) begin
            if (q8.size() == 0) checkOutput("model8_empty", 64'(outValid8), 64'h0);
            else checkOutput("model8", 64'(p8), q8[0]);
        end
    end

    task automatic applyStimulus(input logic [63:0] aIn, input logic [63:0] bIn, input logic sq,
                                 input int hold, input bit useLit, input logic [63:0] lit);
        int n;
        logic [63:0] exp;
        exp = gfMul(aIn, sq ? aIn : bIn, M64, 64'h1B);
        n = 0;
        while (!inReady && n < 200) begin @(negedge clk); n++; end
        if (!inReady) checkOutput("accept_timeout", 64'(inReady), 64'h1);
        outReady = 1'b0;
        inValid  = 1'b1;
        a        = aIn;
        b        = bIn;
        sqMode   = sq;
        @(posedge clk); #1;
        inValid = 1'b0;
        a       = {$urandom, $urandom};
        b       = {$urandom, $urandom};
        sqMode  = 1'($urandom);
        n = 0;
        while (!outValid && n < 200) begin @(posedge clk); #1; n++; end
        checkOutput("latency64", 64'(n), 64'(M64));
        if (useLit) checkOutput("literal64", p, lit);
        for (int i = 0; i < hold; i++) begin
            inValid = 1'b1;
            a       = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("bp_outValid", 64'(outValid), 64'h1);
            checkOutput("bp_p_stable", p, exp);
            @(posedge clk); #1;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("idle_outValid", 64'(outValid), 64'h0);
        checkOutput("idle_inReady", 64'(inReady), 64'h1);
        checkOutput("idle_p_hold", p, exp);
    endtask

    task automatic applyStimulus8(input logic [7:0] aIn, input logic [7:0] bIn, input bit useLit, input logic [7:0] lit);
        int n;
        n = 0;
        while (!inReady8 && n < 50) begin @(negedge clk); n++; end
        inValid8  = 1'b1;
        a8        = aIn;
        b8        = bIn;
        outReady8 = 1'b0;
        @(posedge clk); #1;
        inValid8 = 1'b0;
        n = 0;
        while (!outValid8 && n < 50) begin @(posedge clk); #1; n++; end
        checkOutput("latency8", 64'(n), 64'(M8));
        if (useLit) checkOutput("literal8", 64'(p8), 64'(lit));
        outReady8 = 1'b1;
        @(posedge clk); #1;
        outReady8 = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] x, y;
        int n;
        #12;
        checkOutput("reset_outValid", 64'(outValid), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        checkOutput("reset_p", p, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("release_inReady", 64'(inReady), 64'h1);

        applyStimulus(64'h1, 64'h0123456789ABCDEF, 1'b0, 0, 1'b1, 64'h0123456789ABCDEF);
        applyStimulus(64'h2, 64'h8000000000000000, 1'b0, 0, 1'b1, 64'h1B);
        applyStimulus(64'h8000000000000000, 64'h8000000000000000, 1'b0, 0, 1'b1, 64'hC00000000000005A);
        applyStimulus(64'h3, 64'hFFFF, 1'b1, 0, 1'b1, 64'h5);

        // Backpressure: out_ready low for 20 cycles with in_valid high, then both high together.
        applyStimulus(64'hDEADBEEFCAFEF00D, 64'h0F1E2D3C4B5A6978, 1'b0, 20, 1'b0, 64'h0);
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        @(negedge clk);
        applyStimulus(x, y, 1'b0, 0, 1'b0, 64'h0);
        n = 0;
        outReady = 1'b0;
        inValid  = 1'b1;
        a        = 64'h1;
        b        = 64'h7;
        sqMode   = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0;
        while (!outValid && n < 200) begin @(posedge clk); #1; n++; end
        checkOutput("direct_p", p, 64'h7);
        inValid  = 1'b1;
        a        = 64'h6;
        b        = 64'h3;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        checkOutput("dual_hs_outValid", 64'(outValid), 64'h0);
        checkOutput("dual_hs_inReady", 64'(inReady), 64'h1);
        @(posedge clk); #1;
        inValid = 1'b0;
        checkOutput("dual_hs_accepted", 64'(busy), 64'h1);
        n = 0;
        while (!outValid && n < 200) begin @(posedge clk); #1; n++; end
        checkOutput("dual_hs_p", p, 64'hA);
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;

        // Abort at cnt=30: 33 iterations after the accept edge.
        inValid = 1'b1;
        a       = {$urandom, $urandom};
        b       = {$urandom, $urandom};
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (33) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_outValid", 64'(outValid), 64'h0);
        checkOutput("abort_busy", 64'(busy), 64'h0);
        checkOutput("abort_p", p, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_inReady", 64'(inReady), 64'h1);
        applyStimulus(64'h1, 64'h5, 1'b0, 0, 1'b1, 64'h5);

        applyStimulus8(8'h57, 8'h83, 1'b1, 8'hC1);
        for (int i = 0; i < 20; i++) applyStimulus8(8'($urandom), 8'($urandom), 1'b0, 8'h0);

        for (int i = 0; i < 300; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            applyStimulus(x, y, 1'b0, 0, 1'b0, 64'h0);
            applyStimulus(y, x, 1'($urandom_range(0, 7) == 0), 0, 1'b0, 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
